rr_hold_arb: RTL and testbench
==============================

Name: rr_hold_arb

Overview:
- N-requester round-robin arbiter with grant hold. A requester keeps the shared resource while its request stays high, up to MAX_HOLD cycles when others are contending.
- Generalises the 2-way request/grant arbiter to N ports for shared-resource access in the datapath.
- Grant is registered and one-hot; an encoded owner index is also provided.

Parameters:
- N, 4, number of requesters (2..16, need not be a power of 2)
- ID_W, 2, width of grant_id; must satisfy 2^ID_W >= N
- MAX_HOLD, 8, maximum consecutive grant cycles to one owner while another requester is waiting (>=1)
- CNT_W, 4, hold-counter width; must satisfy 2^CNT_W > MAX_HOLD

Ports:
- clk  in  1  single clock, all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- request  in  N  per-requester request level; bit i is requester i
- grant  out  N  registered one-hot grant; all zeros when idle
- grant_valid  out  1  registered; high when grant is non-zero
- grant_id  out  ID_W  registered index of current owner; 0 when idle

Behaviour:
- Reset, sampled high at an edge:
  - grant=0, grant_valid=0, grant_id=0
  - state=IDLE, rr pointer ptr=0, hold counter cnt=0
  - request is ignored while reset is high.
- Candidate search: the first index j with request[j]=1, scanning cyclically from a start index, wrapping N-1 -> 0. Modulo N, not 2^ID_W.
- Every grant issue is one action that sets:
  - grant=one-hot(j), grant_id=j, grant_valid=1
  - cnt=1
  - ptr=(j+1) mod N
  - state=GRANT
- Latency: a request seen at edge k in IDLE produces grant after edge k. The grant is visible in the cycle after the request is first sampled.
- IDLE:
  - any request bit high -> issue grant to the candidate found from ptr
  - otherwise outputs stay 0.
- GRANT, owner o, evaluated each edge in priority order:
  1. request[o]=0 (release):
     - another request high -> issue grant to the candidate from (o+1) mod N on the same edge. No idle cycle.
     - otherwise -> state=IDLE, grant=0, grant_valid=0, grant_id=0. ptr is unchanged and already equals o+1.
  2. request[o]=1, cnt=MAX_HOLD, another request high (preempt) -> issue grant to the candidate from (o+1) mod N, which excludes o.
  3. request[o]=1, cnt=MAX_HOLD, no other request -> keep grant; cnt saturates at MAX_HOLD. Preemption then happens on the first edge at which another request is seen.
  4. request[o]=1, cnt<MAX_HOLD -> keep grant; cnt=cnt+1.
- Invariants:
  - grant is never multi-hot.
  - grant_valid equals the OR of grant bits.
  - grant_id is consistent with grant.
- Fairness: with all N requesting continuously, each owner gets exactly MAX_HOLD cycles, rotating in index order.
- Reset mid-grant: grant drops to 0 after the reset edge; no partial state survives (ptr returns to 0).
- Request deasserting and reasserting between edges is not visible; only edge-sampled values count.

Test Plan:
1. Reset hold: reset=1 for 3 cycles with request=4'b1111 -> grant=0, grant_valid=0, grant_id=0 throughout. Reset low -> after the next edge, grant=4'b0001, grant_id=0.
2. Solo hold: only request[2] high for 20 cycles -> grant=4'b0100 for all 20 cycles, no drop at MAX_HOLD. request[2] low -> grant=0 after the next edge.
3. Full contention: request=4'b1111 held, MAX_HOLD=8 -> grant sequence is 0001 x8, 0010 x8, 0100 x8, 1000 x8, then 0001 again.
4. Release handoff: request=4'b0101; owner 0 deasserts after 3 grant cycles -> grant goes from 0001 directly to 0100 on that edge, grant_valid never low.
5. Rotation order: owner 1 releases while request[0] and request[3] are high -> grant=4'b1000 (index 3, not 0); ptr becomes 0.
6. Reset mid-grant: owner 2 in its 4th cycle, reset pulsed 1 cycle -> grant=0 after the reset edge. Then request=4'b0110 -> grant=4'b0010, because the search restarts from ptr=0.

Source files
------------

// File: rtl/rr_hold_arb.sv
// rr_hold_arb: N-way round-robin arbiter with bounded grant hold.
// Owner keeps the grant while requesting, up to MAX_HOLD cycles under contention.
module rr_hold_arb #(
    parameter int N        = 4,
    parameter int ID_W     = 2,
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    request,
    output logic [N-1:0]    grant,
    output logic            grant_valid,
    output logic [ID_W-1:0] grant_id
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e            state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N-1:0]      grant_q;
    logic              valid_q;
    logic [ID_W-1:0]   id_q;

    logic              found_d;
    logic [ID_W-1:0]   cand_d;
    logic [ID_W-1:0]   ptr_d;
    logic              own_req;
    logic              others;

    // ptr always equals owner+1 in GRANT, so one cyclic search from ptr
    // serves both the idle case and handoff/preemption past the owner.
    always_comb begin
        int idx;
        found_d = 1'b0;
        cand_d  = '0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            if (!found_d && ((request >> idx) & N'(1)) != '0) begin
                found_d = 1'b1;
                cand_d  = ID_W'(idx);
            end
        end
    end

    // Owner/contention status and the post-issue pointer.
    always_comb begin
        own_req = |(request & grant_q);
        others  = |(request & ~grant_q);
        if (cand_d == ID_W'(N - 1)) ptr_d = '0;
        else                        ptr_d = cand_d + ID_W'(1);
    end

    // Arbitration FSM with registered grant outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= GRANT;
                        grant_q <= N'(1) << cand_d;
                        id_q    <= cand_d;
                        valid_q <= 1'b1;
                        cnt_q   <= CNT_W'(1);
                        ptr_q   <= ptr_d;
                    end
                end
                GRANT: begin
                    if (!own_req) begin
                        if (others) begin
                            grant_q <= N'(1) << cand_d;
                            id_q    <= cand_d;
                            cnt_q   <= CNT_W'(1);
                            ptr_q   <= ptr_d;
                        end else begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            id_q    <= '0;
                            valid_q <= 1'b0;
                        end
                    end else if (cnt_q == CNT_W'(MAX_HOLD)) begin
                        if (others) begin
                            grant_q <= N'(1) << cand_d;
                            id_q    <= cand_d;
                            cnt_q   <= CNT_W'(1);
                            ptr_q   <= ptr_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = valid_q;
    assign grant_id    = id_q;

endmodule

// File: tb/tb_rr_hold_arb.sv
// tb_rr_hold_arb: directed checks of rr_hold_arb (N=4, MAX_HOLD=8).
// Expected grants are hand-derived from the round-robin/hold rules.
module tb_rr_hold_arb;

    logic       clk;
    logic       reset;
    logic [3:0] request;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;

    int total = 0;
    int bad   = 0;

    rr_hold_arb #(
        .N(4), .ID_W(2), .MAX_HOLD(8), .CNT_W(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .request    (request),
        .grant      (grant),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg,
                       input logic [1:0] eid);
        logic [6:0] obs;
        logic [6:0] exp;
        obs = {grant, grant_valid, grant_id};
        exp = {eg, |eg, eid};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got g=%b v=%b id=%0d want g=%b v=%b id=%0d",
                   tag, grant, grant_valid, grant_id, eg, |eg, eid);
        end
    endtask

    initial begin
        int o;
        reset   = 1'b1;
        request = 4'b1111;

        // reset hold with all requesting
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_hold", 4'b0000, 2'd0);
        end
        reset = 1'b0;
        step();
        chk("post_reset", 4'b0001, 2'd0);

        // full contention: 8 cycles per owner, rotating
        for (int i = 1; i < 40; i++) begin
            step();
            o = (i / 8) % 4;
            chk("contention", 4'(1 << o), 2'(o));
        end

        // solo hold past MAX_HOLD
        reset   = 1'b1;
        request = 4'b0000;
        step();
        chk("reset2", 4'b0000, 2'd0);
        reset   = 1'b0;
        request = 4'b0100;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("solo_hold", 4'b0100, 2'd2);
        end
        request = 4'b0000;
        step();
        chk("solo_release", 4'b0000, 2'd0);

        // saturated owner preempted by first new requester (ptr=3)
        request = 4'b0100;
        step();
        chk("resolo", 4'b0100, 2'd2);
        for (int i = 0; i < 9; i++) step();
        chk("sat_hold", 4'b0100, 2'd2);
        request = 4'b0101;
        step();
        chk("sat_preempt", 4'b0001, 2'd0);

        // release handoff without idle cycle
        reset   = 1'b1;
        request = 4'b0000;
        step();
        chk("reset3", 4'b0000, 2'd0);
        reset   = 1'b0;
        request = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("handoff_own", 4'b0001, 2'd0);
        end
        request = 4'b0100;
        step();
        chk("handoff", 4'b0100, 2'd2);

        // rotation order: owner 1 releases, 3 beats 0
        reset   = 1'b1;
        request = 4'b0000;
        step();
        chk("reset4", 4'b0000, 2'd0);
        reset   = 1'b0;
        request = 4'b0010;
        step();
        chk("rot_own1", 4'b0010, 2'd1);
        request = 4'b1011;
        step();
        chk("rot_keep1", 4'b0010, 2'd1);
        request = 4'b1001;
        step();
        chk("rot_to3", 4'b1000, 2'd3);
        request = 4'b0011;
        step();
        chk("rot_wrap0", 4'b0001, 2'd0);

        // reset mid-grant restarts search at 0
        reset   = 1'b1;
        request = 4'b0000;
        step();
        chk("reset5", 4'b0000, 2'd0);
        reset   = 1'b0;
        request = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mid_own2", 4'b0100, 2'd2);
        end
        reset = 1'b1;
        step();
        chk("mid_reset", 4'b0000, 2'd0);
        reset   = 1'b0;
        request = 4'b0110;
        step();
        chk("mid_restart", 4'b0010, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
